gon_tag_sequencer: RTL and testbench

GON_TAG_SEQUENCER -- requirements
Module: gon_tag_sequencer

---
 rtl/gon_tag_sequencer_pkg.sv | 19 +
 rtl/gon_tag_sequencer.sv | 152 +++++++++++++++
 tb/tb_gon_tag_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gon_tag_sequencer_pkg.sv
// Shared GON definitions: sequencer FSM state encoding and default tag widths.
package gon_tag_sequencer_pkg;

  // Default field widths for the GON tag path
  localparam int unsigned GON_ROW_TAG_WIDTH = 4;
  localparam int unsigned GON_COL_TAG_WIDTH = 4;
  localparam int unsigned GON_PASS_WIDTH    = 16;
  localparam int unsigned GON_CNT_WIDTH     = 24;

  localparam int unsigned GON_STATE_WIDTH   = 2;

  // Tag sequencer control states
  typedef enum logic [GON_STATE_WIDTH-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gon_state_e;

endpackage : gon_tag_sequencer_pkg

// File: rtl/gon_tag_sequencer.sv
// GON tag sequencer: walks a rows x cols raster for a number of passes and
// streams (row, col) tags into the GON tags FIFO at up to one tag per cycle.
module gon_tag_sequencer
  import gon_tag_sequencer_pkg::*;
#(
  parameter int unsigned ROW_TAG_WIDTH = GON_ROW_TAG_WIDTH,
  parameter int unsigned COL_TAG_WIDTH = GON_COL_TAG_WIDTH,
  parameter int unsigned PASS_WIDTH    = GON_PASS_WIDTH,
  parameter int unsigned CNT_WIDTH     = GON_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_rows,
  input  logic [COL_TAG_WIDTH-1:0] cfg_cols,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_row_base,
  input  logic [COL_TAG_WIDTH-1:0] cfg_col_base,
  input  logic [PASS_WIDTH-1:0]    cfg_passes,
  output logic [ROW_TAG_WIDTH-1:0] row_tag,
  output logic [COL_TAG_WIDTH-1:0] col_tag,
  output logic                     tags_wr_en,
  input  logic                     tags_full,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     tag_count
);

  gon_state_e state_q;

  // Latched job configuration
  logic [ROW_TAG_WIDTH-1:0] rows_q;
  logic [COL_TAG_WIDTH-1:0] cols_q;
  logic [ROW_TAG_WIDTH-1:0] row_base_q;
  logic [COL_TAG_WIDTH-1:0] col_base_q;
  logic [PASS_WIDTH-1:0]    passes_q;

  // Raster position within the job
  logic [ROW_TAG_WIDTH-1:0] row_cnt;
  logic [COL_TAG_WIDTH-1:0] col_cnt;
  logic [PASS_WIDTH-1:0]    pass_cnt;

  logic cfg_empty;
  logic col_last;
  logic row_last;
  logic pass_last;
  logic job_last;

  // A zero in any dimension means the job has no tags at all
  assign cfg_empty = (cfg_rows == '0) | (cfg_cols == '0) | (cfg_passes == '0);

  // Raster wrap points; only meaningful in RUN where all dimensions are nonzero
  assign col_last  = (col_cnt  == (cols_q   - COL_TAG_WIDTH'(1)));
  assign row_last  = (row_cnt  == (rows_q   - ROW_TAG_WIDTH'(1)));
  assign pass_last = (pass_cnt == (passes_q - PASS_WIDTH'(1)));
  assign job_last  = col_last & row_last & pass_last;

  // FIFO write strobe must react to full/abort in the same cycle
  assign tags_wr_en = (state_q == ST_RUN) & ~tags_full & ~abort;

  // Counters sit at zero outside RUN, so the tags show the latched bases there
  assign row_tag = row_base_q + row_cnt;
  assign col_tag = col_base_q + col_cnt;

  // Control FSM, configuration latch, raster counters and tag counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      passes_q   <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      pass_cnt   <= '0;
      tag_count  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            rows_q     <= cfg_rows;
            cols_q     <= cfg_cols;
            row_base_q <= cfg_row_base;
            col_base_q <= cfg_col_base;
            passes_q   <= cfg_passes;
            row_cnt    <= '0;
            col_cnt    <= '0;
            pass_cnt   <= '0;
            tag_count  <= '0;
            if (cfg_empty) begin
              state_q <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy    <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (abort) begin
            // Cancelled job: drop position, keep the tag count for software
            state_q  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            pass_cnt <= '0;
          end else if (tags_wr_en) begin
            tag_count <= tag_count + CNT_WIDTH'(1);
            if (col_last) begin
              col_cnt <= '0;
              if (row_last) begin
                row_cnt <= '0;
                if (pass_last) begin
                  pass_cnt <= '0;
                  state_q  <= ST_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                end else begin
                  pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                end
              end else begin
                row_cnt <= row_cnt + ROW_TAG_WIDTH'(1);
              end
            end else begin
              col_cnt <= col_cnt + COL_TAG_WIDTH'(1);
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule : gon_tag_sequencer

// File: tb/tb_gon_tag_sequencer.sv
// Scoreboard bench for gon_tag_sequencer: expected tags come from a nested-loop
// raster model, a negedge monitor pops and compares on every FIFO write.
module tb_gon_tag_sequencer;

  localparam int RW = 4;
  localparam int CW = 4;
  localparam int PW = 16;
  localparam int NW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tags_full = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [CW-1:0] cfg_cols = '0;
  logic [RW-1:0] cfg_row_base = '0;
  logic [CW-1:0] cfg_col_base = '0;
  logic [PW-1:0] cfg_passes = '0;
  logic [RW-1:0] row_tag;
  logic [CW-1:0] col_tag;
  logic          tags_wr_en;
  logic          busy;
  logic          done;
  logic [NW-1:0] tag_count;

  gon_tag_sequencer #(
    .ROW_TAG_WIDTH(RW),
    .COL_TAG_WIDTH(CW),
    .PASS_WIDTH   (PW),
    .CNT_WIDTH    (NW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_rows    (cfg_rows),
    .cfg_cols    (cfg_cols),
    .cfg_row_base(cfg_row_base),
    .cfg_col_base(cfg_col_base),
    .cfg_passes  (cfg_passes),
    .row_tag     (row_tag),
    .col_tag     (col_tag),
    .tags_wr_en  (tags_wr_en),
    .tags_full   (tags_full),
    .busy        (busy),
    .done        (done),
    .tag_count   (tag_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
  } tag_t;

  tag_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done_due = 1'b0;
  bit   done_pending = 1'b0;
  bit   done_seen = 1'b0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: compares every write and the done pulse timing against the model
  always @(negedge clk) begin
    tag_t e;
    if (reset) begin
      if (done_due) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_timing: got done=%b want 1 (t=%0t)", done, $time);
        end
        done_due = 1'b0;
      end else if (done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 want 0 (t=%0t)", $time);
      end
      if (done === 1'b1) begin
        done_seen    = 1'b1;
        done_pending = 1'b0;
      end
      if (tags_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got row=%0d col=%0d want no write (t=%0t)",
                   row_tag, col_tag, $time);
        end else begin
          e = exp_q.pop_front();
          if (row_tag !== RW'(e.r) || col_tag !== CW'(e.c)) begin
            errors++;
            $display("FAIL tag_order: got (%0d,%0d) want (%0d,%0d) (t=%0t)",
                     row_tag, col_tag, e.r, e.c, $time);
          end
          if (exp_q.size() == 0 && done_pending) done_due = 1'b1;
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    done_pending = 1'b0;
    done_due     = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tags_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Issue one job: model pushes expected tags, then drive cycles until done
  task automatic run_job(input int rows, input int cols, input int rb, input int cb,
                         input int passes, input int full_mode, input int abort_cyc,
                         input bit mid_start);
    int total;
    int cyc;
    int limit;
    tag_t t;
    total = rows * cols * passes;
    for (int p = 0; p < passes; p++)
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) begin
          t.r = (rb + r) % (1 << RW);
          t.c = (cb + c) % (1 << CW);
          exp_q.push_back(t);
        end
    done_pending = (total != 0);
    done_seen    = 1'b0;
    cfg_rows     = RW'(rows);
    cfg_cols     = CW'(cols);
    cfg_row_base = RW'(rb);
    cfg_col_base = CW'(cb);
    cfg_passes   = PW'(passes);
    start        = 1'b1;
    cyc   = 0;
    limit = total * 4 + 20;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      start     = 1'b0;
      abort     = 1'b0;
      tags_full = 1'b0;
      if (done_seen) break;
      if (cyc > limit) begin
        chk("timeout_done", 0, 1);
        apply_reset();
        return;
      end
      if (cyc == 1) chk("busy_after_start", busy, (total != 0) ? 1 : 0);
      if (cyc == 1 && total == 0) done_due = 1'b1;
      if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
        exp_q.delete();
        done_pending = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tag_count", tag_count, abort_cyc - 1);
        chk("abort_row_base", row_tag, rb % (1 << RW));
        chk("abort_col_base", col_tag, cb % (1 << CW));
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_write_idle", tags_wr_en, 0);
        return;
      end
      if (abort_cyc != 0 && cyc == abort_cyc) abort = 1'b1;
      if (full_mode == 1) tags_full = (cyc >= 2 && cyc <= 4);
      else if (full_mode == 2) tags_full = ($urandom_range(0, 3) == 0);
      if (mid_start && cyc == 2 && total >= 3) start = 1'b1;
    end
    chk("job_tag_count", tag_count, total);
    chk("job_busy_idle", busy, 0);
    chk("job_row_base", row_tag, rb % (1 << RW));
    chk("job_col_base", col_tag, cb % (1 << CW));
    chk("job_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_wr_en", tags_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tag_count", tag_count, 0);
    chk("rst_row_tag", row_tag, 0);
    chk("rst_col_tag", col_tag, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Abort in IDLE does nothing
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // Basic 2x3 raster, no stalls
    run_job(2, 3, 0, 0, 1, 0, 0, 1'b0);
    // Same job with three stall cycles
    run_job(2, 3, 0, 0, 1, 1, 0, 1'b0);
    // Row tag wrap across two passes
    run_job(4, 1, 14, 0, 2, 0, 0, 1'b0);
    // Empty job
    run_job(2, 0, 3, 5, 1, 0, 0, 1'b0);
    run_job(0, 4, 0, 0, 3, 0, 0, 1'b0);
    // Abort on third write cycle of a 12-tag job, then restart cleanly
    run_job(3, 4, 2, 7, 1, 0, 3, 1'b0);
    run_job(3, 4, 2, 7, 1, 0, 0, 1'b0);

    // Asynchronous reset mid-run
    begin
      tag_t t;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) begin
          t.r = 5 + r;
          t.c = 9 + c;
          exp_q.push_back(t);
        end
      done_pending = 1'b1;
      cfg_rows = 4'd3; cfg_cols = 4'd4; cfg_row_base = 4'd5; cfg_col_base = 4'd9;
      cfg_passes = 16'd1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("arst_wr_en", tags_wr_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_tag_count", tag_count, 0);
      chk("arst_row_tag", row_tag, 0);
      chk("arst_col_tag", col_tag, 0);
      apply_reset();
      @(posedge clk);
      #1;
      run_job(3, 4, 5, 9, 1, 0, 0, 1'b0);
    end

    // Randomized jobs with random stalls and ignored restarts
    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 3), 2, 0,
              1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_gon_tag_sequencer
